// File: rtl/div_sequencer.sv
// Control FSM for a restoring divider: operand load, accumulator seeding, WIDTH shift/trial-subtract iterations.
// Optional divide-by-zero trap (ERR state, dvz pulse) is built when DIV_SEQ_DVZ_EN is defined.
module div_sequencer #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             sub_neg,
    input  logic             divisor_zero,
    output logic             ld_operands,
    output logic             acc_init,
    output logic             loading_done,
    output logic             shift,
    output logic             acc_ld,
    output logic             q_bit,
    output logic [CNT_W-1:0] iter,
    output logic             busy,
    output logic             done,
    output logic             dvz
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        INIT = 3'd2,
        ITER = 3'd3,
        DONE = 3'd4
`ifdef DIV_SEQ_DVZ_EN
        ,
        ERR  = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] ITER_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] iter_r;
    logic [CNT_W-1:0] iter_s;

`ifndef DIV_SEQ_DVZ_EN
    logic unused_divisor_zero_s;
    assign unused_divisor_zero_s = divisor_zero;
`endif

    assign iter = iter_r;

    // State and iteration counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= IDLE;
            iter_r  <= ITER_ZERO;
        end else begin
            state_r <= state_s;
            iter_r  <= iter_s;
        end
    end

    // Next-state decode plus state-decoded strobes; acc_ld/q_bit follow sub_neg combinationally in ITER.
    always_comb begin
        state_s      = IDLE;
        iter_s       = ITER_ZERO;
        ld_operands  = 1'b0;
        acc_init     = 1'b0;
        loading_done = 1'b0;
        shift        = 1'b0;
        acc_ld       = 1'b0;
        q_bit        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        dvz          = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                ld_operands = 1'b1;
                busy        = 1'b1;
`ifdef DIV_SEQ_DVZ_EN
                if (divisor_zero) begin
                    state_s = ERR;
                end else begin
                    state_s = INIT;
                end
`else
                state_s = INIT;
`endif
            end
            INIT: begin
                acc_init     = 1'b1;
                loading_done = 1'b1;
                busy         = 1'b1;
                state_s      = ITER;
            end
            ITER: begin
                loading_done = 1'b1;
                shift        = 1'b1;
                busy         = 1'b1;
                acc_ld       = ~sub_neg;
                q_bit        = ~sub_neg;
                // Counter wraps to zero on the last pass so DONE and IDLE report iter = 0.
                if (iter_r == ITER_LAST) begin
                    state_s = DONE;
                    iter_s  = ITER_ZERO;
                end else begin
                    state_s = ITER;
                    iter_s  = iter_r + ITER_ONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_s = IDLE;
            end
`ifdef DIV_SEQ_DVZ_EN
            ERR: begin
                done    = 1'b1;
                dvz     = 1'b1;
                busy    = 1'b1;
                state_s = IDLE;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench: behavioural restoring-divider datapath closes the sub_neg loop; a queue holds expected quotient bits.
module tb_div_sequencer;
    localparam int W = 10;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sub_neg;
    logic          divisor_zero = 1'b0;
    logic          ld_operands, acc_init, loading_done, shift, acc_ld, q_bit, busy, done, dvz;
    logic [CW-1:0] iter;

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] dvd = '0;
    logic [W-1:0] dvs = '0;
    logic         force_neg = 1'b0;
    logic [W:0]   ma = '0;
    logic [W-1:0] mq = '0;
    logic [W-1:0] mm = '0;
    logic [W:0]   shifted_s;
    logic [W:0]   trial_s;
    bit           sb[$];

    div_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock(clock), .rst(rst), .start(start), .sub_neg(sub_neg), .divisor_zero(divisor_zero),
        .ld_operands(ld_operands), .acc_init(acc_init), .loading_done(loading_done), .shift(shift),
        .acc_ld(acc_ld), .q_bit(q_bit), .iter(iter), .busy(busy), .done(done), .dvz(dvz)
    );

    always #5 clock = ~clock;

    // Restoring-division datapath reference driven by the sequencer strobes.
    assign shifted_s = {ma[W-1:0], mq[W-1]};
    assign trial_s   = shifted_s - {1'b0, mm};
    assign sub_neg   = force_neg | trial_s[W];

    always @(posedge clock) begin
        if (ld_operands) begin
            mq <= dvd;
            mm <= dvs;
        end
        if (acc_init) ma <= '0;
        if (shift) begin
            ma <= acc_ld ? trial_s : shifted_s;
            mq <= {mq[W-2:0], q_bit};
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ld"}, ld_operands, 0);
        check({tag, "_init"}, acc_init, 0);
        check({tag, "_shift"}, shift, 0);
        check({tag, "_accld"}, acc_ld, 0);
        check({tag, "_iter"}, iter, 0);
        check({tag, "_dvz"}, dvz, 0);
    endtask

    // One full operation checked cycle by cycle; k counts cycles after the edge that samples start.
    task automatic run_op(input int a, input int b, input bit fneg, input int pulse_k,
                          input bit hold, input bit started);
        logic [W-1:0] exp_q;
        int           exp_r;
        bit           eb;
        if (b == 0) begin
            exp_q = '1;
            exp_r = a;
        end else begin
            exp_q = W'(a / b);
            exp_r = a % b;
        end
        if (fneg) exp_q = '0;
        dvd = W'(a);
        dvs = W'(b);
        divisor_zero = (b == 0);
        force_neg = fneg;
        sb.delete();
        for (int i = W - 1; i >= 0; i--) sb.push_back(exp_q[i]);
        if (!started) begin
            @(negedge clock);
            start = 1'b1;
        end
        @(posedge clock);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clock);
            check("ld_operands", ld_operands, int'(k == 1));
            check("acc_init", acc_init, int'(k == 2));
            check("loading_done", loading_done, int'(k >= 2 && k <= 12));
            check("shift", shift, int'(k >= 3 && k <= 12));
            check("done", done, int'(k == 13));
            check("busy", busy, 1);
            check("dvz", dvz, 0);
            if (k >= 3 && k <= 12) begin
                check("iter", iter, k - 3);
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    eb = sb.pop_front();
                    check("q_bit", q_bit, int'(eb));
                    check("acc_ld", acc_ld, int'(eb));
                end
            end else begin
                check("iter_idle", iter, 0);
                check("acc_ld_off", acc_ld, 0);
            end
            if (k == 13 && !fneg) begin
                check("final_q", mq, int'(exp_q));
                check("remainder", ma, exp_r);
            end
            if (k == 1) start = 1'b0;
            if (k == pulse_k) start = 1'b1;
            if (k == pulse_k + 1) start = 1'b0;
            if (hold && k == pulse_k + 2) start = 1'b1;
        end
        force_neg = 1'b0;
        divisor_zero = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        rst = 1'b0;

        run_op(100, 7, 1'b0, 0, 1'b0, 1'b0);
        run_op(100, 7, 1'b1, 0, 1'b0, 1'b0);
        run_op(1023, 1, 1'b0, 0, 1'b0, 1'b0);
        run_op(5, 9, 1'b0, 0, 1'b0, 1'b0);
        run_op(1000, 31, 1'b0, 0, 1'b0, 1'b0);

`ifdef DIV_SEQ_DVZ_EN
        dvd = 10'd50;
        dvs = 10'd0;
        divisor_zero = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("dvz_load", ld_operands, 1);
        start = 1'b0;
        @(negedge clock);
        check("dvz_done", done, 1);
        check("dvz_flag", dvz, 1);
        check("dvz_busy", busy, 1);
        check("dvz_shift", shift, 0);
        check("dvz_init", acc_init, 0);
        @(negedge clock);
        check_idle("dvz_after");
        divisor_zero = 1'b0;
`else
        run_op(100, 0, 1'b0, 0, 1'b0, 1'b0);
`endif

        // Start pulse mid-ITER is ignored; a held start re-triggers after one IDLE cycle.
        run_op(300, 17, 1'b0, 7, 1'b1, 1'b0);
        @(negedge clock);
        check_idle("gap");
        run_op(200, 3, 1'b0, 0, 1'b0, 1'b1);

        // Reset during ITER with iter = 4.
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
        end
        check("pre_rst_iter", iter, 4);
        rst = 1'b1;
        @(negedge clock);
        check_idle("mid_rst");
        rst = 1'b0;
        run_op(77, 5, 1'b0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Control FSM for the restoring-division datapath.
- Sits directly upstream of the accumulator register and drives its rst, ld, shift and loading_done inputs.
- Also drives the dividend/divisor load strobes and the quotient-bit insertion.
- Runs one shift/trial-subtract iteration per clock and reports completion to the host with a start/busy/done handshake.

Parameters:
- WIDTH, 10, operand width; equals the number of iterations.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  host request; sampled only in IDLE.
- sub_neg  input  1  sign bit of the trial-subtraction result (sub_result[WIDTH]); 1 = negative.
- divisor_zero  input  1  divisor operand equals 0; used only when DIV_SEQ_DVZ_EN is defined.
- ld_operands  output  1  load the dividend (Q) and divisor registers.
- acc_init  output  1  drives the accumulator rst input (clear and seed).
- loading_done  output  1  enables the accumulator; high in INIT and ITER.
- shift  output  1  accumulator/Q shift enable.
- acc_ld  output  1  accumulator ld; commits sub_result.
- q_bit  output  1  quotient bit shifted into Q LSB.
- iter  output  CNT_W  current iteration index.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- dvz  output  1  divide-by-zero flag; one-cycle pulse coincident with done.

Behaviour:
- One clock domain. Reset is synchronous and active-high: a rising edge with rst=1 forces IDLE, iter=0, and all outputs 0.
- States: IDLE, LOAD, INIT, ITER, DONE, plus ERR when DIV_SEQ_DVZ_EN is defined.
- IDLE: all outputs 0.
  - start=1 at an edge -> LOAD.
  - start=0 -> stay in IDLE.
- LOAD: ld_operands=1, busy=1, then -> INIT.
  - With DIV_SEQ_DVZ_EN defined and divisor_zero=1 in this cycle -> ERR instead.
- INIT: acc_init=1, loading_done=1, busy=1; iter cleared to 0; then -> ITER.
- ITER: loading_done=1, shift=1, busy=1.
  - acc_ld = ~sub_neg and q_bit = ~sub_neg. These are Mealy outputs, combinational from sub_neg in the same cycle.
  - sub_neg=0: the accumulator commits the difference and 1 enters the quotient.
  - sub_neg=1: the accumulator shifts the restored value and 0 enters the quotient.
  - iter increments each ITER cycle.
  - iter==WIDTH-1 -> DONE; otherwise stay in ITER.
  - Exactly WIDTH ITER cycles per operation.
- DONE: done=1, busy=1, all datapath strobes 0; then -> IDLE unconditionally.
  - A start held high re-triggers on the following IDLE cycle, so operations run back to back with a one-cycle IDLE gap.
- ERR: done=1, dvz=1, busy=1; then -> IDLE.
  - No accumulator or Q write occurs after LOAD.
- Latency: start sampled at edge E0.
  - LOAD spans E0–E1.
  - INIT spans E1–E2.
  - ITER spans E2–E(WIDTH+2).
  - done is high during E(WIDTH+2)–E(WIDTH+3); for WIDTH=10 that is cycle 13 after the start edge.
  - Divide-by-zero case: done/dvz high during E1–E2.
- start while busy: ignored; no queueing.
- rst mid-operation: next state IDLE, outputs 0 in the following cycle. A partial result left in the datapath is don't-care.
- Output exclusivity: at most one of ld_operands, acc_init and shift is high in any cycle. acc_ld implies shift.
- sub_neg and divisor_zero are ignored outside ITER and LOAD respectively.
- Illegal or unreached state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: DIV_SEQ_DVZ_EN.
- Defined:
  - The ERR state exists.
  - divisor_zero is checked in LOAD.
  - dvz pulses together with done.
- Undefined:
  - The ERR state is not built and divisor_zero is ignored.
  - dvz is tied to 0.
  - A zero divisor runs the full WIDTH iterations. The datapath then yields quotient all-ones and remainder equal to the dividend.

Test Plan:
- rst=1 for 2 cycles, then start=1 for 1 cycle -> after reset all outputs 0. ld_operands high in cycle 1, acc_init in cycle 2, shift high in cycles 3–12, done high only in cycle 13, busy high in cycles 1–13.
- Bench datapath model, dividend=100, divisor=7 -> q_bit sequence MSB first = 0,0,0,0,0,0,1,1,1,0. Final Q=14, remainder=2, with done asserted.
- sub_neg forced 1 in every ITER cycle -> acc_ld=0 and q_bit=0 for all 10 cycles; iter steps 0..9, then DONE.
- DIV_SEQ_DVZ_EN defined, divisor_zero=1, start -> done=1 and dvz=1 in cycle 2; no shift or acc_init asserted. Macro undefined -> 10 ITER cycles, q_bit=1 throughout, dvz=0.
- start pulsed in ITER cycle 5, then start held high continuously -> first operation unaffected, then IDLE for 1 cycle, then LOAD of the second operation.
- rst asserted in ITER cycle with iter=4 -> next cycle IDLE, iter=0, busy=0, shift=0. A subsequent start completes in 13 cycles.
